// File: rtl/video_capture.sv
// Purpose: window, decimate and tag a VGA pixel stream as (x,y,r,g,b) records.
// Latency: out_valid rises 2 CLOCK_50 cycles after the pix_en sampling edge (FIFO empty).
// Backpressure: out_valid/out_ready FIFO; a record arriving while full is dropped and sets overflow.
module video_capture #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       pix_en,
  input  logic       vid_hs,
  input  logic       vid_vs,
  input  logic       vid_de,
  input  logic [7:0] vid_r,
  input  logic [7:0] vid_g,
  input  logic [7:0] vid_b,
  output logic [9:0] out_x,
  output logic [8:0] out_y,
  output logic [7:0] out_r,
  output logic [7:0] out_g,
  output logic [7:0] out_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_start,
  output logic       frame_done,
  output logic       frame_abort,
  output logic       overflow,
  input  logic       ovf_clear
);

  localparam int BLOCK   = ((640 / WIDTH) < (480 / HEIGHT)) ? (640 / WIDTH) : (480 / HEIGHT);
  localparam int X_START = (640 - WIDTH * BLOCK) / 2;
  localparam int Y_START = (480 - HEIGHT * BLOCK) / 2;
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [9:0] X_LO   = 10'(X_START);
  localparam logic [9:0] Y_LO   = 10'(Y_START);
  localparam logic [9:0] X_SPAN = 10'(WIDTH * BLOCK);
  localparam logic [9:0] Y_SPAN = 10'(HEIGHT * BLOCK);
  localparam logic [9:0] BLK_M1 = 10'(BLOCK - 1);
  localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

  typedef enum logic [1:0] {SEEK, ARMED, CAPTURE} state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rec_t;

  // Input stage: current and previous pix_en samples.
  logic       s_vld, s_hs, s_vs, s_de, p_vs, p_de;
  logic [7:0] s_r, s_g, s_b;

  // Counters: raw position, decimation phase and logical position.
  logic [9:0] cx, cy, xd, yd, lx;
  logic [8:0] ly;
  logic [9:0] cx_off, cy_off;
  logic       x_in, y_in, vs_fall, de_fall, samp, first_px;

  state_t state, state_nx;
  logic   cap, push, last, first, abort;

  // Push stage and FIFO.
  rec_t          rec_q;
  logic          rec_vld, fs_q, fd_q, fa_q;
  rec_t          mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, pop, wr_en, drop;
  rec_t          head;

  // hsync is captured for future line-timing use; nothing consumes it yet.
  logic unused_hs;
  assign unused_hs = s_hs;

  // Register the stream only on pix_en; s_vld marks the cycle after a sample.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      s_vld <= 1'b0;
      s_hs  <= 1'b0;
      s_vs  <= 1'b0;
      s_de  <= 1'b0;
      p_vs  <= 1'b0;
      p_de  <= 1'b0;
      s_r   <= '0;
      s_g   <= '0;
      s_b   <= '0;
    end else begin
      s_vld <= pix_en;
      if (pix_en) begin
        p_vs <= s_vs;
        p_de <= s_de;
        s_hs <= vid_hs;
        s_vs <= vid_vs;
        s_de <= vid_de;
        s_r  <= vid_r;
        s_g  <= vid_g;
        s_b  <= vid_b;
      end
    end
  end

  // Offsets wrap below the window start, so a single compare covers both bounds.
  assign cx_off   = cx - X_LO;
  assign cy_off   = cy - Y_LO;
  assign x_in     = cx_off < X_SPAN;
  assign y_in     = cy_off < Y_SPAN;
  assign vs_fall  = s_vld & p_vs & ~s_vs;
  assign de_fall  = s_vld & p_de & ~s_de;
  assign samp     = s_vld & s_de & x_in & y_in & (xd == '0) & (yd == '0);
  assign first_px = s_vld & s_de & (cx == '0) & (cy == '0);

  // Raw, decimation and logical counters; a vsync falling edge restarts everything.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cx <= '0;
      cy <= '0;
      xd <= '0;
      yd <= '0;
      lx <= '0;
      ly <= '0;
    end else if (s_vld) begin
      if (vs_fall) begin
        cx <= '0;
        cy <= '0;
        xd <= '0;
        yd <= '0;
        lx <= '0;
        ly <= '0;
      end else begin
        if (s_de) begin
          cx <= cx + 10'd1;
          if (x_in) begin
            xd <= (xd == BLK_M1) ? '0 : xd + 10'd1;
            if (xd == BLK_M1) lx <= lx + 10'd1;
          end
        end else begin
          cx <= '0;
          xd <= '0;
          lx <= '0;
        end
        if (de_fall) begin
          cy <= cy + 10'd1;
          if (y_in) begin
            yd <= (yd == BLK_M1) ? '0 : yd + 10'd1;
            if (yd == BLK_M1) ly <= ly + 9'd1;
          end
        end
      end
    end
  end

  // Frame alignment state register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= SEEK;
    else          state <= state_nx;
  end

  // ARMED only starts on the first pixel of a frame, so trailing lines after
  // frame_done cannot start a bogus capture that later aborts.
  always_comb begin
    state_nx = state;
    cap      = 1'b0;
    abort    = 1'b0;
    case (state)
      SEEK:    if (vs_fall) state_nx = ARMED;
      ARMED:   if (!vs_fall && first_px) begin
                 state_nx = CAPTURE;
                 cap      = 1'b1;
               end
      CAPTURE: if (vs_fall) begin
                 abort    = 1'b1;
                 state_nx = ARMED;
               end else begin
                 cap = 1'b1;
               end
      default: state_nx = SEEK;
    endcase
    push  = cap & samp;
    last  = push & (lx == X_LAST) & (ly == Y_LAST);
    first = push & (lx == '0) & (ly == '0);
    if (last) state_nx = ARMED;
  end

  // Push stage: record and frame pulses are presented together to the FIFO.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      rec_q   <= '0;
      rec_vld <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      fa_q    <= 1'b0;
    end else begin
      rec_vld <= push;
      fs_q    <= first;
      fd_q    <= last;
      fa_q    <= abort;
      if (push) rec_q <= '{x: lx, y: ly, r: s_r, g: s_g, b: s_b};
    end
  end

  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign frame_abort = fa_q;

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid = (wr_ptr != rd_ptr);
  assign pop       = out_valid & out_ready;
  assign wr_en     = rec_vld & (~full | pop);
  assign drop      = rec_vld & full & ~pop;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_x     = head.x;
  assign out_y     = head.y;
  assign out_r     = head.r;
  assign out_g     = head.g;
  assign out_b     = head.b;

  // FIFO storage is reset so an empty head reads as zero rather than X.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= rec_q;
    end
  end

  // FIFO pointers; simultaneous push and pop on a full FIFO both proceed.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky overflow; a drop in the same cycle as ovf_clear keeps it set.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n)       overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (ovf_clear) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_video_capture.sv
// Bench for video_capture with a 200x200 window (BLOCK=2, X_START=120, Y_START=40).
// Pixel colour encodes its raw coordinates so every record reveals its source.
module tb_video_capture;

  localparam int W   = 200;
  localparam int H   = 200;
  localparam int D   = 4;
  localparam int BLK = 2;
  localparam int XS  = 120;
  localparam int YS  = 40;

  logic       clk = 1'b0;
  logic       reset_n, pix_en, vid_hs, vid_vs, vid_de, out_ready, ovf_clear;
  logic [7:0] vid_r, vid_g, vid_b, out_r, out_g, out_b;
  logic [9:0] out_x;
  logic [8:0] out_y;
  logic       out_valid, frame_start, frame_done, frame_abort, overflow;

  always #10 clk = ~clk;

  video_capture #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .CLOCK_50(clk), .reset_n(reset_n), .pix_en(pix_en),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
    .out_x(out_x), .out_y(out_y), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .frame_start(frame_start), .frame_done(frame_done), .frame_abort(frame_abort),
    .overflow(overflow), .ovf_clear(ovf_clear)
  );

  typedef struct { int x; int y; int rgb; } exp_t;
  typedef struct { int cx; int cy; int x; int y; } got_t;
  typedef struct { int cx; int cy; bit hit; int x; int y; } probe_t;

  exp_t   exp_q[$];
  got_t   got_q[$];
  probe_t probes[15];

  int n_err = 0, n_chk = 0;
  int n_fs = 0, n_fd = 0, n_ab = 0, hold_cnt = 0;
  bit fs_seen = 0, fd_seen = 0, exp_on = 0, hold = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic bit in_win(input int cx, input int cy);
    return cx >= XS && cx < XS + W * BLK && (cx - XS) % BLK == 0 &&
           cy >= YS && cy < YS + H * BLK && (cy - YS) % BLK == 0;
  endfunction

  function automatic int enc_rgb(input int cx, input int cy);
    logic [9:0] c, r;
    c = cx[9:0];
    r = cy[9:0];
    return {8'h00, c[7:0], 4'h0, r[9:8], c[9:8], r[7:0]};
  endfunction

  // Compare the FIFO head against the scoreboard whenever it is accepted.
  task automatic monitor();
    exp_t e;
    got_t g;
    if (frame_start) begin n_fs++; fs_seen = 1; end
    if (frame_done)  begin n_fd++; fd_seen = 1; end
    if (frame_abort) n_ab++;
    if (out_valid && out_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_record: got x=%0d y=%0d, expected none", out_x, out_y);
      end else begin
        e = exp_q.pop_front();
        chk("rec_x", int'(out_x), e.x);
        chk("rec_y", int'(out_y), e.y);
        chk("rec_rgb", int'({out_r, out_g, out_b}), e.rgb);
      end
      if (fs_seen) begin chk("frame_start_rec", int'({out_x, out_y}), 0); fs_seen = 0; end
      if (fd_seen) begin
        chk("frame_done_rec", int'({out_x, out_y}), ((W - 1) << 9) | (H - 1));
        fd_seen = 0;
      end
      g.cx = int'({out_g[1:0], out_r});
      g.cy = int'({out_g[3:2], out_b});
      g.x  = int'(out_x);
      g.y  = int'(out_y);
      got_q.push_back(g);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (reset_n) monitor();
    @(posedge clk);
    #1;
  endtask

  // One pixel at 25 MHz cadence; lat=1 checks out_valid after each of the next edges.
  task automatic drive_px(input bit de, input bit vs, input bit hs, input int cx, input int cy,
                          input bit lat);
    int rgb;
    exp_t e;
    rgb    = enc_rgb(cx, cy);
    pix_en = 1'b1;
    vid_de = de;
    vid_vs = vs;
    vid_hs = hs;
    vid_r  = de ? rgb[23:16] : 8'd0;
    vid_g  = de ? rgb[15:8]  : 8'd0;
    vid_b  = de ? rgb[7:0]   : 8'd0;
    if (de && exp_on && in_win(cx, cy)) begin
      if (!(hold && hold_cnt >= D)) begin
        e.x   = (cx - XS) / BLK;
        e.y   = (cy - YS) / BLK;
        e.rgb = rgb;
        exp_q.push_back(e);
      end
      if (hold) hold_cnt++;
    end
    tick();
    pix_en = 1'b0;
    if (lat) begin
      chk("lat_edge0", int'(out_valid), 0);
      tick();
      chk("lat_edge1", int'(out_valid), 0);
      tick();
      chk("lat_edge2", int'(out_valid), 1);
    end else begin
      tick();
    end
  endtask

  task automatic drive_seg(input int cy, input int lo, input int hi);
    for (int c = lo; c < hi; c++) drive_px(1'b1, 1'b1, 1'b1, c, cy, 1'b0);
  endtask

  task automatic end_line();
    drive_px(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    drive_px(1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
  endtask

  task automatic short_rows(input int from, input int to);
    for (int r = from; r < to; r++) begin
      drive_px(1'b1, 1'b1, 1'b1, 0, r, 1'b0);
      end_line();
    end
  endtask

  task automatic vsync();
    drive_px(1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
    drive_px(1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    drive_px(1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    drive_px(1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_q.size() != 0 || out_valid); i++) tick();
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    bit found;
    int gx, gy;
    probes[0]  = '{120, 40, 1'b1, 0, 0};
    probes[1]  = '{121, 40, 1'b0, 0, 0};
    probes[2]  = '{119, 40, 1'b0, 0, 0};
    probes[3]  = '{518, 40, 1'b1, 199, 0};
    probes[4]  = '{520, 40, 1'b0, 0, 0};
    probes[5]  = '{122, 41, 1'b0, 0, 0};
    probes[6]  = '{122, 42, 1'b1, 1, 1};
    probes[7]  = '{2,   42, 1'b0, 0, 0};
    probes[8]  = '{124, 44, 1'b1, 2, 2};
    probes[9]  = '{120, 46, 1'b1, 0, 3};
    probes[10] = '{130, 46, 1'b0, 0, 0};
    probes[11] = '{140, 46, 1'b1, 10, 3};
    probes[12] = '{518, 438, 1'b1, 199, 199};
    probes[13] = '{519, 439, 1'b0, 0, 0};
    probes[14] = '{518, 439, 1'b0, 0, 0};

    reset_n = 1'b0; pix_en = 1'b0; vid_hs = 1'b1; vid_vs = 1'b1; vid_de = 1'b0;
    vid_r = 8'd0; vid_g = 8'd0; vid_b = 8'd0; out_ready = 1'b1; ovf_clear = 1'b0;
    tick(); tick();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_xy", int'({out_x, out_y}), 0);
    chk("rst_rgb", int'({out_r, out_g, out_b}), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_pulses", int'({frame_start, frame_done, frame_abort}), 0);
    reset_n = 1'b1;
    tick();

    // Partial frame before any vsync must be discarded.
    short_rows(0, 42); drive_seg(42, 0, 640); end_line(); short_rows(43, 44);
    vsync();
    chk("seek_no_start", n_fs, 0);

    // Main frame.
    exp_on = 1;
    short_rows(0, 40);
    drive_seg(40, 0, 120); drive_px(1'b1, 1'b1, 1'b1, 120, 40, 1'b1); drive_seg(40, 121, 640); end_line();
    drive_seg(41, 0, 640); end_line();
    drive_seg(42, 0, 640); end_line();
    short_rows(43, 44);
    drive_seg(44, 0, 640); end_line();
    short_rows(45, 46);
    drive_seg(46, 0, 120);
    out_ready = 1'b0; hold = 1; hold_cnt = 0;
    drive_seg(46, 120, 140);
    chk("hold_valid", int'(out_valid), 1);
    chk("hold_head_xy", int'({out_x, out_y}), (0 << 9) | 3);
    repeat (3) tick();
    hold = 0;
    chk("hold_head_stable", int'({out_x, out_y}), 3);
    chk("hold_head_r", int'(out_r), 120);
    chk("ovf_set", int'(overflow), 1);
    out_ready = 1'b1;
    drive_seg(46, 140, 640); end_line();
    short_rows(47, 48);
    chk("ovf_sticky", int'(overflow), 1);
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    chk("ovf_clear", int'(overflow), 0);
    short_rows(48, 438);
    drive_seg(438, 0, 640); end_line();
    drive_seg(439, 0, 640); end_line();
    short_rows(440, 480);
    drain();
    chk("main_fs", n_fs, 1);
    chk("main_fd", n_fd, 1);
    chk("main_abort", n_ab, 0);
    vsync();
    chk("clean_vs_no_abort", n_ab, 0);

    // Frame aborted by vsync at row 100.
    short_rows(0, 100);
    drive_seg(100, 0, 131); end_line();
    drain();
    vsync();
    repeat (3) tick();
    chk("abort_count", n_ab, 1);
    chk("abort_no_done", n_fd, 1);

    // Next frame, then reset mid-line with records still queued.
    short_rows(0, 40);
    out_ready = 1'b0;
    drive_seg(40, 0, 126);
    repeat (3) tick();
    chk("pre_reset_valid", int'(out_valid), 1);
    chk("after_abort_fs", n_fs, 2);
    reset_n = 1'b0;
    #1;
    chk("reset_valid_now", int'(out_valid), 0);
    exp_q.delete(); fs_seen = 0; fd_seen = 0; exp_on = 0;
    tick();
    reset_n = 1'b1; out_ready = 1'b1;
    drive_seg(40, 126, 300); end_line();
    short_rows(41, 46);
    chk("seek_after_reset_fs", n_fs, 2);
    vsync();
    exp_on = 1;
    short_rows(0, 40);
    drive_seg(40, 0, 126); end_line();
    drain();
    chk("post_reset_fs", n_fs, 3);
    chk("final_abort", n_ab, 1);

    // Raw-to-logical mapping table.
    for (int i = 0; i < 15; i++) begin
      found = 0; gx = 0; gy = 0;
      foreach (got_q[j]) begin
        if (got_q[j].cx == probes[i].cx && got_q[j].cy == probes[i].cy) begin
          found = 1; gx = got_q[j].x; gy = got_q[j].y;
        end
      end
      chk($sformatf("probe%0d_hit", i), int'(found), int'(probes[i].hit));
      if (probes[i].hit) begin
        chk($sformatf("probe%0d_x", i), gx, probes[i].x);
        chk($sformatf("probe%0d_y", i), gy, probes[i].y);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/video_capture.md
Name: video_capture

Overview:
- Receive-side counterpart of the VGA output driver. Takes a VGA-format pixel stream (sync, data-enable, 8-bit RGB, qualified by a pixel strobe).
- Picks out a centred WIDTH x HEIGHT window with integer decimation and converts it into logical (x,y,r,g,b) write records.
- Records pass through a small FIFO with a valid/ready handshake toward a frame-buffer writer.
- Tracks frame alignment and flags overflow and aborted frames.

Parameters:
- WIDTH, 640, logical output width in pixels.
- HEIGHT, 480, logical output height in pixels.
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.
- Derived: BLOCK = min(640/WIDTH, 480/HEIGHT).
- Derived: X_START = (640-WIDTH*BLOCK)/2, Y_START = (480-HEIGHT*BLOCK)/2.

Ports:
- CLOCK_50  in  1  system clock; sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- pix_en  in  1  one-cycle strobe; input stream valid this cycle (25 MHz cadence).
- vid_hs  in  1  horizontal sync, active-low.
- vid_vs  in  1  vertical sync, active-low.
- vid_de  in  1  data enable; high during active 640x480 pixels.
- vid_r, vid_g, vid_b  in  8 each  pixel colour.
- out_x  out  10  logical column of the record at the FIFO head.
- out_y  out  9  logical row.
- out_r, out_g, out_b  out  8 each  colour.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head this cycle.
- frame_start  out  1  pulse: record (0,0) pushed.
- frame_done  out  1  pulse: record (WIDTH-1,HEIGHT-1) pushed.
- frame_abort  out  1  pulse: vsync arrived mid-capture.
- overflow  out  1  sticky: a record was dropped because the FIFO was full.
- ovf_clear  in  1  synchronous clear of overflow.

Behaviour:
- Reset (reset_n low, asynchronous): FIFO emptied, out_valid=0, all out_* data=0, pulses=0, overflow=0, counters=0, state=SEEK.
- Input stage: all vid_* are registered only on pix_en cycles. Edge detection compares the current pix_en sample against the previous pix_en sample; cycles without pix_en are ignored.
- Raw counters:
  - cx counts active pixels per line; increments on each pix_en with de=1; cleared on pix_en with de=0.
  - cy counts active lines; increments on a de falling edge; cleared on a vs falling edge.
- Decimation counters:
  - xd, yd in 0..BLOCK-1; xd reloads at the start of each line, yd at frame start.
  - Sample taken when X_START <= cx < X_START+WIDTH*BLOCK and xd==0, and the same for cy/yd.
  - Logical x = (cx-X_START)/BLOCK and y = (cy-Y_START)/BLOCK, kept as incrementing counters, never dividers.
- State machine:
  - SEEK: wait for a vs falling edge -> ARMED. Any partial frame after reset is discarded.
  - ARMED: wait for the first de=1 sample -> CAPTURE.
  - CAPTURE: push sampled pixels.
    - After pushing (WIDTH-1,HEIGHT-1), pulse frame_done and go to ARMED.
    - If a vs falling edge arrives first, pulse frame_abort, clear counters, go to ARMED.
- Push timing: the push occurs on the CLOCK_50 cycle after the pix_en sample.
- Latency: with the FIFO empty, out_valid rises 2 CLOCK_50 cycles after the pix_en sampling edge.
- frame_start and frame_done are each one CLOCK_50 cycle wide, coincident with the push.
- FIFO:
  - Pop when out_valid & out_ready. out_* hold stable while out_valid=1 and out_ready=0.
  - Push when full and no pop: record dropped, overflow<=1, x/y counters still advance.
  - Full with simultaneous push and pop: both occur; no drop.
  - Empty: out_valid=0; out_* data are don't-care, but no X propagation.
  - Wrap-around: pointers are log2(FIFO_DEPTH) bits plus a wrap bit.
- Overflow flag: cleared by ovf_clear; if ovf_clear and a drop occur in the same cycle, the set wins.
- hs is not used for counting; de alone delimits lines. hs is registered for future use only.
- Mid-frame reset: immediate return to SEEK; the next full frame is captured cleanly.

Test Plan:
- 640x480 defaults, one full frame after an initial vs, out_ready=1 -> exactly 307200 records in raster order; frame_start with (0,0); frame_done with (639,479); overflow=0.
- WIDTH=320, HEIGHT=240 (BLOCK=2) -> records only at even cx/cy; raw pixel (2,4) maps to (1,2); 76800 records.
- WIDTH=200, HEIGHT=200 (BLOCK=2, X_START=120, Y_START=40) -> first record from raw (120,40) as (0,0); raw (519,439) never produces a record; last record from raw (518,438).
- Hold out_ready=0 for 10 pixels with FIFO_DEPTH=4 -> 4 records retained, 6 dropped, overflow=1 and held until ovf_clear; later records carry correct x/y.
- vs falls mid-frame at row 100 -> frame_abort pulses once; the next frame starts at (0,0); no frame_done for the aborted frame.
- reset_n pulsed low mid-line -> out_valid=0 immediately; no records until a vs edge followed by de; the first record after that is (0,0).
